// File: rtl/apb_arbiter.sv
// apb_arbiter -- two-master to one-slave APB arbiter.
//
// Purpose: grants the shared slave to one of two APB masters (round-robin
// when both request, master 0 first after reset), runs the slave through
// SETUP/ACCESS, returns the slave response to the granted master, and forces
// an error completion if the slave stalls ACCESS for TIMEOUT cycles.
//
// Ports:
//   pclk, prst                         clock, async active-high reset
//   mN_psel/paddr/pdata/pwrite/pstb    master N request fields (N = 0, 1)
//   mN_prdata/pready/perr              master N response (zero unless granted)
//   s_psel/penable/pwrite/paddr/pdata/pstb   slave request
//   s_prdata/pready/perr               slave response
//   grant                              one-hot slave owner, 2'b00 when none

// Per-master response gating: a master only ever sees the slave response
// while it holds the grant.
module apb_arb_port #(
  parameter int DW = 32
) (
  input  logic          sel,
  input  logic          done,
  input  logic          err,
  input  logic          data_ok,
  input  logic [DW-1:0] s_prdata,
  output logic          pready,
  output logic          perr,
  output logic [DW-1:0] prdata
);
  assign pready = sel & done;
  assign perr   = sel & err;
  assign prdata = (sel & data_ok) ? s_prdata : '0;
endmodule

module apb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  prst,
  // master 0
  input  logic                  m0_psel,
  input  logic [ADDR_WIDTH-1:0] m0_paddr,
  input  logic [DATA_WIDTH-1:0] m0_pdata,
  input  logic                  m0_pwrite,
  input  logic [3:0]            m0_pstb,
  output logic [DATA_WIDTH-1:0] m0_prdata,
  output logic                  m0_pready,
  output logic                  m0_perr,
  // master 1
  input  logic                  m1_psel,
  input  logic [ADDR_WIDTH-1:0] m1_paddr,
  input  logic [DATA_WIDTH-1:0] m1_pdata,
  input  logic                  m1_pwrite,
  input  logic [3:0]            m1_pstb,
  output logic [DATA_WIDTH-1:0] m1_prdata,
  output logic                  m1_pready,
  output logic                  m1_perr,
  // slave
  output logic                  s_psel,
  output logic                  s_penable,
  output logic                  s_pwrite,
  output logic [ADDR_WIDTH-1:0] s_paddr,
  output logic [DATA_WIDTH-1:0] s_pdata,
  output logic [3:0]            s_pstb,
  input  logic [DATA_WIDTH-1:0] s_prdata,
  input  logic                  s_pready,
  input  logic                  s_perr,
  output logic [1:0]            grant
);
  localparam int NUM_M = 2;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  write;
    logic [3:0]            stb;
  } req_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, GAP} state_t;

  state_t                           state;
  logic [7:0]                       cnt;
  logic                             last;   // 1 = master 1 served last
  logic                             psel_q, pen_q;
  logic [NUM_M-1:0]                 psel;
  logic [NUM_M-1:0]                 win;
  req_t [NUM_M-1:0]                 req;
  req_t                             s_req;
  logic                             in_access, to_hit, done, err, data_ok;
  logic [NUM_M-1:0]                 pready, perr;
  logic [NUM_M-1:0][DATA_WIDTH-1:0] prdata;

  assign psel   = {m1_psel, m0_psel};
  assign req[0] = '{addr: m0_paddr, data: m0_pdata, write: m0_pwrite, stb: m0_pstb};
  assign req[1] = '{addr: m1_paddr, data: m1_pdata, write: m1_pwrite, stb: m1_pstb};

  // Contention goes to whichever master was not served last; a lone
  // requester's psel is already the one-hot grant.
  always_comb begin
    win = psel;
    if (psel == 2'b11) win = last ? 2'b01 : 2'b10;
  end

  // A slave response on the final allowed cycle beats the timeout.
  assign in_access = (state == ACCESS);
  assign to_hit    = in_access & ~s_pready & (cnt == TO_LAST);
  assign done      = in_access & (s_pready | to_hit);
  assign err       = in_access & (s_pready ? s_perr : to_hit);
  assign data_ok   = in_access & ~to_hit;

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state  <= IDLE;
      grant  <= 2'b00;
      cnt    <= '0;
      last   <= 1'b1;
      psel_q <= 1'b0;
      pen_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|psel) begin
          grant  <= win;
          cnt    <= '0;
          psel_q <= 1'b1;
          state  <= SETUP;
        end
        SETUP: begin
          pen_q <= 1'b1;
          state <= ACCESS;
        end
        ACCESS: if (done) begin
          psel_q <= 1'b0;
          pen_q  <= 1'b0;
          state  <= GAP;
        end else begin
          cnt <= cnt + 8'd1;
        end
        // One dead cycle so the finished master can drop psel before
        // it would be considered for arbitration again.
        GAP: begin
          last  <= grant[1];
          grant <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // psel_q is high exactly in SETUP and ACCESS.
  assign s_req     = psel_q ? req[grant[1]] : '0;
  assign s_psel    = psel_q;
  assign s_penable = pen_q;
  assign s_paddr   = s_req.addr;
  assign s_pdata   = s_req.data;
  assign s_pwrite  = s_req.write;
  assign s_pstb    = s_req.stb;

  for (genvar n = 0; n < NUM_M; n++) begin : g_port
    apb_arb_port #(.DW(DATA_WIDTH)) u_port (
      .sel     (grant[n]),
      .done    (done),
      .err     (err),
      .data_ok (data_ok),
      .s_prdata(s_prdata),
      .pready  (pready[n]),
      .perr    (perr[n]),
      .prdata  (prdata[n])
    );
  end

  assign m0_pready = pready[0];
  assign m0_perr   = perr[0];
  assign m0_prdata = prdata[0];
  assign m1_pready = pready[1];
  assign m1_perr   = perr[1];
  assign m1_prdata = prdata[1];
endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: reset, single write, contention order,
// round-robin, timeout, timeout/ready tie, slave error, reset mid-transfer.
module tb_apb_arbiter;
  logic        pclk = 1'b0;
  logic        prst;
  logic        m0_psel, m1_psel, m0_pwrite, m1_pwrite;
  logic [31:0] m0_paddr, m1_paddr, m0_pdata, m1_pdata;
  logic [3:0]  m0_pstb, m1_pstb;
  logic [31:0] m0_prdata, m1_prdata;
  logic        m0_pready, m1_pready, m0_perr, m1_perr;
  logic        s_psel, s_penable, s_pwrite;
  logic [31:0] s_paddr, s_pdata, s_prdata;
  logic [3:0]  s_pstb;
  logic        s_pready, s_perr;
  logic [1:0]  grant;

  int checks = 0;
  int failures = 0;

  apb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .pclk(pclk), .prst(prst),
    .m0_psel(m0_psel), .m0_paddr(m0_paddr), .m0_pdata(m0_pdata),
    .m0_pwrite(m0_pwrite), .m0_pstb(m0_pstb),
    .m0_prdata(m0_prdata), .m0_pready(m0_pready), .m0_perr(m0_perr),
    .m1_psel(m1_psel), .m1_paddr(m1_paddr), .m1_pdata(m1_pdata),
    .m1_pwrite(m1_pwrite), .m1_pstb(m1_pstb),
    .m1_prdata(m1_prdata), .m1_pready(m1_pready), .m1_perr(m1_perr),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pdata(s_pdata), .s_pstb(s_pstb),
    .s_prdata(s_prdata), .s_pready(s_pready), .s_perr(s_perr),
    .grant(grant)
  );

  always #5 pclk = ~pclk;

  // Advance one clock; inputs are driven and outputs sampled 2 time units
  // after the rising edge.
  task automatic tick;
    @(posedge pclk);
    #2;
  endtask

  task automatic test_reset;
    prst = 1'b1;
    m0_psel = 0; m1_psel = 0; m0_pwrite = 0; m1_pwrite = 0;
    m0_paddr = 0; m1_paddr = 0; m0_pdata = 0; m1_pdata = 0;
    m0_pstb = 0; m1_pstb = 0;
    s_prdata = 0; s_pready = 0; s_perr = 0;
    #3;
    checks++;
    if ({s_psel, s_penable, grant, m0_pready, m0_perr, m1_pready, m1_perr} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000000",
               {s_psel, s_penable, grant, m0_pready, m0_perr, m1_pready, m1_perr});
    end
    checks++;
    if ({s_paddr, s_pdata, s_pstb, s_pwrite} !== '0) begin
      failures++;
      $display("FAIL reset_slave_fields got addr=%h data=%h exp=0", s_paddr, s_pdata);
    end
    repeat (2) @(posedge pclk);
    #2 prst = 1'b0;
    tick;
    checks++;
    if ({s_psel, grant} !== 3'b000) begin
      failures++;
      $display("FAIL post_reset_idle got=%b exp=000", {s_psel, grant});
    end
  endtask

  task automatic test_single_write;
    m0_psel = 1; m0_paddr = 32'h100; m0_pdata = 32'hDEADBEEF; m0_pwrite = 1; m0_pstb = 4'hF;
    s_pready = 1; s_perr = 0;
    #1;
    checks++;
    if (s_psel !== 1'b0) begin
      failures++; $display("FAIL wr_idle_psel got=%b exp=0", s_psel);
    end
    tick; // SETUP
    checks++;
    if ({s_psel, s_penable, grant} !== 4'b1001) begin
      failures++; $display("FAIL wr_setup got=%b exp=1001", {s_psel, s_penable, grant});
    end
    checks++;
    if ({s_paddr, s_pdata, s_pwrite, s_pstb} !== {32'h100, 32'hDEADBEEF, 1'b1, 4'hF}) begin
      failures++;
      $display("FAIL wr_setup_fields got addr=%h data=%h w=%b stb=%h exp 100/DEADBEEF/1/F",
               s_paddr, s_pdata, s_pwrite, s_pstb);
    end
    checks++;
    if (m0_pready !== 1'b0) begin
      failures++; $display("FAIL wr_setup_pready got=%b exp=0", m0_pready);
    end
    tick; // ACCESS, slave ready
    checks++;
    if ({s_psel, s_penable, m0_pready, m0_perr, m1_pready} !== 5'b11100) begin
      failures++;
      $display("FAIL wr_access got=%b exp=11100", {s_psel, s_penable, m0_pready, m0_perr, m1_pready});
    end
    m0_psel = 0;
    tick; // GAP
    checks++;
    if ({s_psel, grant, m0_pready, (s_paddr == 32'h0)} !== 5'b00101) begin
      failures++;
      $display("FAIL wr_gap got psel=%b grant=%b pready=%b addr=%h exp 0/01/0/0",
               s_psel, grant, m0_pready, s_paddr);
    end
    tick; // IDLE, cycle 5
    checks++;
    if ({s_psel, grant} !== 3'b000) begin
      failures++; $display("FAIL wr_idle_after got=%b exp=000", {s_psel, grant});
    end
    tick;
  endtask

  task automatic test_both_read;
    int m0_setup = -1;
    int m1_setup = -1;
    bit got_m1 = 0;
    prst = 1; #1 prst = 0; // restore master 0 priority
    m0_psel = 1; m0_pwrite = 0; m0_paddr = 32'h200;
    m1_psel = 1; m1_pwrite = 0; m1_paddr = 32'h300;
    s_prdata = 32'h12345678; s_pready = 1; s_perr = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      tick;
      if (s_psel && !s_penable) begin
        if (grant == 2'b01 && m0_setup < 0) m0_setup = cyc;
        if (grant == 2'b10 && m1_setup < 0) m1_setup = cyc;
      end
      if (m0_pready) m0_psel = 0;
      if (m1_pready && !got_m1) begin
        got_m1 = 1;
        checks++;
        if (m1_prdata !== 32'h12345678) begin
          failures++; $display("FAIL rd_m1_prdata got=%h exp=12345678", m1_prdata);
        end
        checks++;
        if (m0_prdata !== 32'h0) begin
          failures++; $display("FAIL rd_m0_prdata_ungranted got=%h exp=0", m0_prdata);
        end
        m1_psel = 0;
      end
    end
    checks++;
    if (m0_setup !== 1) begin
      failures++; $display("FAIL rd_m0_first got=%0d exp=1", m0_setup);
    end
    checks++;
    if (m1_setup - m0_setup !== 4) begin
      failures++; $display("FAIL rd_m1_setup_gap got=%0d exp=4", m1_setup - m0_setup);
    end
    checks++;
    if (!got_m1) begin
      failures++; $display("FAIL rd_m1_timeout got=0 exp=1");
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] g [6];
    int n = 0;
    m0_psel = 1; m1_psel = 1; s_pready = 1; s_perr = 0;
    for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
      tick;
      if (s_psel && !s_penable) begin
        g[n] = grant;
        n++;
      end
    end
    checks++;
    if (n !== 6) begin
      failures++; $display("FAIL rr_count got=%0d exp=6", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (g[i] !== ((i % 2) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL rr_grant_%0d got=%b exp=%b", i, g[i], (i % 2) ? 2'b10 : 2'b01);
      end
    end
    // Drop both requests during SETUP; the transfer must still complete.
    m0_psel = 0; m1_psel = 0;
    tick;
    checks++;
    if ({m1_pready, m0_pready} !== 2'b10) begin
      failures++; $display("FAIL rr_dropped_completes got=%b exp=10", {m1_pready, m0_pready});
    end
    repeat (3) tick;
    checks++;
    if ({s_psel, grant} !== 3'b000) begin
      failures++; $display("FAIL rr_idle got=%b exp=000", {s_psel, grant});
    end
  endtask

  task automatic test_timeout;
    int early = 0;
    m0_psel = 1; m0_pwrite = 0; m0_paddr = 32'h400;
    s_pready = 0; s_perr = 0; s_prdata = 32'hCAFEF00D;
    tick; // SETUP
    tick; // ACCESS cycle 1
    for (int i = 1; i <= 15; i++) begin
      if (m0_pready) early++;
      tick;
    end
    // ACCESS cycle 16
    checks++;
    if (early !== 0) begin
      failures++; $display("FAIL to_early_pready got=%0d exp=0", early);
    end
    checks++;
    if ({s_penable, m0_pready, m0_perr} !== 3'b111) begin
      failures++; $display("FAIL to_strobe got=%b exp=111", {s_penable, m0_pready, m0_perr});
    end
    checks++;
    if (m0_prdata !== 32'h0) begin
      failures++; $display("FAIL to_prdata got=%h exp=0", m0_prdata);
    end
    m0_psel = 0;
    tick; // GAP
    checks++;
    if ({s_psel, grant, m0_pready} !== 4'b0010) begin
      failures++; $display("FAIL to_gap got=%b exp=0010", {s_psel, grant, m0_pready});
    end
    tick;
  endtask

  task automatic test_timeout_tie;
    m1_psel = 1; m1_pwrite = 0; m1_paddr = 32'h500;
    s_pready = 0; s_perr = 0; s_prdata = 32'h5A5A5A5A;
    tick; // SETUP
    tick; // ACCESS cycle 1
    repeat (15) tick; // ACCESS cycle 16
    s_pready = 1;
    #1;
    checks++;
    if ({m1_pready, m1_perr, m0_pready} !== 3'b100) begin
      failures++; $display("FAIL tie_strobe got=%b exp=100", {m1_pready, m1_perr, m0_pready});
    end
    checks++;
    if (m1_prdata !== 32'h5A5A5A5A) begin
      failures++; $display("FAIL tie_prdata got=%h exp=5A5A5A5A", m1_prdata);
    end
    m1_psel = 0;
    tick; // GAP
    tick; // IDLE
  endtask

  task automatic test_slave_error;
    m0_psel = 1; m0_pwrite = 1; m0_paddr = 32'h101; m0_pdata = 32'h55; m0_pstb = 4'b0010;
    s_pready = 1; s_perr = 1;
    tick; // SETUP
    checks++;
    if (s_paddr !== 32'h101) begin
      failures++; $display("FAIL err_addr got=%h exp=101", s_paddr);
    end
    tick; // ACCESS
    checks++;
    if ({m0_pready, m0_perr, m1_perr} !== 3'b110) begin
      failures++; $display("FAIL err_perr got=%b exp=110", {m0_pready, m0_perr, m1_perr});
    end
    m0_psel = 0; s_perr = 0;
    tick;
    tick;
  endtask

  task automatic test_reset_mid;
    int strobes = 0;
    m1_psel = 1; m1_pwrite = 1; m1_paddr = 32'h300; s_pready = 0;
    tick; // SETUP
    tick; // ACCESS
    checks++;
    if ({s_psel, s_penable, grant} !== 4'b1110) begin
      failures++; $display("FAIL rstmid_pre got=%b exp=1110", {s_psel, s_penable, grant});
    end
    #1 prst = 1;
    #1;
    checks++;
    if ({s_psel, s_penable, grant, m1_pready} !== 5'b00000) begin
      failures++;
      $display("FAIL rstmid_async got=%b exp=00000", {s_psel, s_penable, grant, m1_pready});
    end
    m1_psel = 0; s_pready = 1;
    @(posedge pclk);
    #2 prst = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (m1_pready || m0_pready) strobes++;
    end
    checks++;
    if (strobes !== 0) begin
      failures++; $display("FAIL rstmid_no_strobe got=%0d exp=0", strobes);
    end
    // Arbitration restarts with master 0 priority.
    m0_psel = 1; m1_psel = 1;
    tick;
    checks++;
    if ({s_psel, s_penable, grant} !== 4'b1001) begin
      failures++; $display("FAIL rstmid_restart got=%b exp=1001", {s_psel, s_penable, grant});
    end
    m0_psel = 0; m1_psel = 0;
    repeat (3) tick;
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_both_read;
    test_round_robin;
    test_timeout;
    test_timeout_tie;
    test_slave_error;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
